// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One transaction in flight: accept in IDLE, operands to ALU in EXEC, response held in RESP.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  input  logic [7:0]              req_op,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_result,
  output logic [2:0]              rsp_flags,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [3:0]              alu_op,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_overflow,
  input  logic                    alu_carryout
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   sel;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign sel       = req_ready[1];
  assign rsp_valid = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 4'b0000;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready != 2'b00) begin
            grant  <= sel;
            alu_a  <= sel ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
            alu_b  <= sel ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
            alu_op <= sel ? req_op[7:4] : req_op[3:0];
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_overflow, alu_carryout, alu_zero};
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and an expected-response scoreboard.
module tb_alu_arbiter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [7:0]     req_op;
  logic [W-1:0]   rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]     rsp_flags;
  logic [3:0]     alu_op;
  logic           alu_zero, alu_overflow, alu_carryout;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carryout(alu_carryout)
  );

  // Shared ALU; unknown opcodes give zero result with all flags clear.
  logic [W:0] wide;
  logic       op_known;
  always_comb begin
    wide         = '0;
    op_known     = 1'b1;
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_carryout = 1'b0;
    case (alu_op)
      4'd0:  alu_result = alu_a & alu_b;
      4'd1:  alu_result = alu_a | alu_b;
      4'd2: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = wide[W-1:0];
        alu_carryout = wide[W];
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      4'd3: begin
        alu_result   = alu_a - alu_b;
        alu_carryout = alu_a < alu_b;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      4'd4:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd5:  alu_result = {31'd0, alu_a < alu_b};
      4'd6:  alu_result = alu_a << alu_b[4:0];
      4'd7:  alu_result = alu_a >> alu_b[4:0];
      4'd8:  alu_result = alu_a << alu_b[4:0];
      4'd9:  alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'd10: alu_result = {alu_b[15:0], 16'h0000};
      4'd11: alu_result = alu_a ^ alu_b;
      4'd12: alu_result = ~(alu_a | alu_b);
      default: op_known = 1'b0;
    endcase
    alu_zero = op_known && (alu_result == '0);
  end

  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic [W-1:0] res;
    logic [2:0]   fl;
  } job_t;

  typedef struct {
    int           port;
    job_t         job;
    int           due;
  } sb_t;

  job_t q0[$];
  job_t q1[$];
  sb_t  sb[$];
  int   glog[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   exp_last = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_job(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op, input logic [W-1:0] res, input logic [2:0] fl);
    job_t j;
    j.a = a; j.b = b; j.op = op; j.res = res; j.fl = fl;
    if (port == 0) q0.push_back(j);
    else q1.push_back(j);
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
    chk("rst_rsp_flags", {61'd0, rsp_flags}, 64'd0);
    chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
    chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
    chk("rst_alu_op", {60'd0, alu_op}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_op = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    check_reset_vals();
    rst = 1'b0;
    sb.delete(); glog.delete();
    exp_last = 1'b1;
  endtask

  // Runs until all queued jobs are answered, or stops at the first response cycle when abort is set.
  task automatic run(input int max_cyc, input int stall, input bit abort);
    int n = 0, scnt = 0;
    bit done = 1'b0, rsp_hs;
    logic [1:0] exp_ready, exp_rv;
    job_t j;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      req_valid = {q1.size() > 0, q0.size() > 0};
      req_a  = {(q1.size() > 0) ? q1[0].a  : 32'd0, (q0.size() > 0) ? q0[0].a  : 32'd0};
      req_b  = {(q1.size() > 0) ? q1[0].b  : 32'd0, (q0.size() > 0) ? q0[0].b  : 32'd0};
      req_op = {(q1.size() > 0) ? q1[0].op : 4'd0,  (q0.size() > 0) ? q0[0].op : 4'd0};
      exp_rv = 2'b00;
      if (sb.size() > 0 && cyc >= sb[0].due) exp_rv = (sb[0].port == 1) ? 2'b10 : 2'b01;
      rsp_ready = (abort || (exp_rv != 2'b00 && scnt < stall)) ? 2'b00 : 2'b11;
      #1;
      exp_ready = 2'b00;
      if (sb.size() == 0) begin
        case (req_valid)
          2'b01:   exp_ready = 2'b01;
          2'b10:   exp_ready = 2'b10;
          2'b11:   exp_ready = exp_last ? 2'b01 : 2'b10;
          default: exp_ready = 2'b00;
        endcase
      end
      chk("req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
      chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, exp_rv});
      if (sb.size() > 0 && cyc > sb[0].due - 2) begin
        chk("alu_a", {32'd0, alu_a}, {32'd0, sb[0].job.a});
        chk("alu_b", {32'd0, alu_b}, {32'd0, sb[0].job.b});
        chk("alu_op", {60'd0, alu_op}, {60'd0, sb[0].job.op});
      end
      rsp_hs = 1'b0;
      if (exp_rv != 2'b00) begin
        chk("rsp_result", {32'd0, rsp_result}, {32'd0, sb[0].job.res});
        chk("rsp_flags", {61'd0, rsp_flags}, {61'd0, sb[0].job.fl});
        if (abort) done = 1'b1;
        else if (rsp_ready != 2'b00) rsp_hs = 1'b1;
        else scnt++;
      end
      if (!done) begin
        @(posedge clk);
        if (rsp_hs) begin
          exp_last = (sb[0].port == 1);
          void'(sb.pop_front());
          scnt = 0;
        end
        if (exp_ready != 2'b00) begin
          if (exp_ready[1]) j = q1.pop_front();
          else j = q0.pop_front();
          sb.push_back('{port: int'(exp_ready[1]), job: j, due: cyc + 2});
          glog.push_back(int'(exp_ready[1]));
        end
        cyc++; n++;
        done = (q0.size() == 0 && q1.size() == 0 && sb.size() == 0);
      end
    end
    chk("run_complete", {63'd0, done}, 64'd1);
  endtask

  initial begin
    do_reset();

    // Single port 0 ADD
    add_job(0, 32'd5, 32'd3, 4'b0010, 32'd8, 3'b000);
    run(50, 0, 1'b0);

    // Tie after reset: port 0 first
    do_reset();
    add_job(0, 32'd7, 32'd7, 4'b0011, 32'd0, 3'b001);
    add_job(1, 32'hF0, 32'h0F, 4'b0001, 32'hFF, 3'b000);
    run(50, 0, 1'b0);
    chk("tie_grant0", glog.size() > 0 ? 64'(glog[0]) : 64'd9, 64'd0);
    chk("tie_grant1", glog.size() > 1 ? 64'(glog[1]) : 64'd9, 64'd1);

    // Both ports held valid for four transactions
    glog.delete();
    add_job(0, 32'hFF, 32'h0F, 4'b1011, 32'hF0, 3'b000);
    add_job(0, 32'hFFFF_FFFF, 32'd1, 4'b0100, 32'd1, 3'b000);
    add_job(1, 32'd0, 32'h1234, 4'b1010, 32'h1234_0000, 3'b000);
    add_job(1, 32'h8000_0000, 32'd4, 4'b1001, 32'hF800_0000, 3'b000);
    run(80, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), glog.size() > i ? 64'(glog[i]) : 64'd9, 64'(i % 2));

    // Overflow with a five-cycle response stall
    add_job(1, 32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 3'b100);
    run(50, 5, 1'b0);

    // Unused opcode
    add_job(0, 32'h1234, 32'h5678, 4'b1111, 32'd0, 3'b000);
    run(50, 0, 1'b0);

    // Reset while the response is pending
    add_job(0, 32'hAA, 32'h55, 4'b0011, 32'h55, 3'b000);
    run(50, 0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check_reset_vals();
    rst = 1'b0;
    sb.delete();
    exp_last = 1'b1;
    rsp_ready = 2'b00;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    end
    add_job(0, 32'hF0, 32'h3C, 4'b0000, 32'h30, 3'b000);
    run(50, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width per port.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  bit p: requester p presents an operation.
REQ-005 req_ready  output  2  bit p: arbiter accepts requester p this cycle.
REQ-006 req_a  input  2*DATA_WIDTH  operand A; port p at [p*DATA_WIDTH +: DATA_WIDTH].
REQ-007 req_b  input  2*DATA_WIDTH  operand B; same packing.
REQ-008 req_op  input  8  ALU opcode; port p at [p*4 +: 4].
REQ-009 rsp_valid  output  2  bit p: response for port p is available.
REQ-010 rsp_ready  input  2  bit p: requester p consumes the response.
REQ-011 rsp_result  output  DATA_WIDTH  result of the transaction being returned.
REQ-012 rsp_flags  output  3  {overflow, carryout, zero} of that transaction.
REQ-013 alu_a  output  DATA_WIDTH  operand A to shared ALU.
REQ-014 alu_b  output  DATA_WIDTH  operand B to shared ALU.
REQ-015 alu_op  output  4  opcode to shared ALU (0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLT, 0101 SLTU, 0110 SLL, 0111 SRL, 1000 SAL, 1001 SRA, 1010 LUI, 1011 XOR, 1100 NOR).
REQ-016 alu_result  input  DATA_WIDTH  combinational ALU result.
REQ-017 alu_zero / alu_overflow / alu_carryout  input  1 each  combinational ALU flags.

Function
REQ-018 FSM states IDLE, EXEC, RESP; exactly one transaction in flight.
REQ-019 IDLE: if no req_valid bit set, req_ready = 00, stay IDLE.
REQ-020 IDLE: if exactly one req_valid bit set, that port is granted.
REQ-021 IDLE: if both set, grant the port not equal to last_grant (round-robin).
REQ-022 req_ready is combinational, set only for granted port, only in IDLE; zero in EXEC and RESP.
REQ-023 On handshake (valid&ready) operands, opcode and grant index registered; FSM -> EXEC.
REQ-024 alu_a, alu_b, alu_op are registered outputs driven from captured values; held unchanged until next accept.
REQ-025 EXEC: lasts exactly one cycle; at its end alu_result and flags captured into rsp_result/rsp_flags; FSM -> RESP.
REQ-026 RESP: rsp_valid[grant] = 1, other bit 0; rsp_result/rsp_flags stable while rsp_valid high.
REQ-027 RESP: on rsp_ready[grant]=1, rsp_valid drops next cycle, last_grant <= grant, FSM -> IDLE.
REQ-028 rsp_ready on non-granted bit ignored; rsp_ready while not in RESP ignored.
REQ-029 Latency: accept in cycle N -> rsp_valid high in cycle N+2; minimum 3 cycles per transaction.
REQ-030 New request accepted no earlier than the cycle after response handshake (no IDLE bypass).
REQ-031 Opcodes 1101-1111 forwarded unchanged; returned result/flags are whatever ALU produces (0, 000).
REQ-032 Requester of a non-granted port keeps req_valid and operands stable; arbiter never drops a pending request.
REQ-033 No data-dependent behaviour; arbiter does not inspect operands or results.

Reset
REQ-034 rst sampled high: FSM -> IDLE, last_grant <= 1 (port 0 wins first tie).
REQ-035 Reset values: req_ready 00, rsp_valid 00, rsp_result 0, rsp_flags 000, alu_a 0, alu_b 0, alu_op 0000.
REQ-036 Reset mid-transaction (EXEC or RESP) discards it; no response issued afterwards.

Verification
REQ-037 Single port 0: A=5, B=3, op=0010 -> req_ready[0]=1 same cycle, rsp_valid=01 two cycles later, result 8, flags 000.
REQ-038 Both ports valid after reset: port0 SUB 7-7, port1 OR 0xF0|0x0F -> port0 first (result 0, flags 001), then port1 (result 0xFF).
REQ-039 Both ports held valid for 4 transactions -> grants alternate 0,1,0,1; no starvation.
REQ-040 Overflow: port1 ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, carryout=0; rsp_ready held low 5 cycles -> rsp_valid and data stable throughout.
REQ-041 Opcode 1111 -> result 0, flags 000; FSM returns to IDLE after handshake.
REQ-042 rst asserted in RESP -> next cycle rsp_valid 00, all outputs at reset values; subsequent port0 AND 0xF0&0x3C returns 0x30.
